// File: rtl/sram_like_responder.sv
// sram_like_responder: sram-like bus target with in-order outstanding queue, fixed response delay and optional random addr_ok backpressure.
module sram_like_responder #(
  parameter int AW = 10,
  parameter int DEPTH = 4,
  parameter int RESP_DELAY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        stall_en
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(RESP_DELAY) + 1;
  logic [31:0]      mem [2**AW];
  logic [DEPTH-1:0] valid;
  logic [31:0]      qdata [DEPTH];
  logic [TW-1:0]    timer [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count;
  logic [7:0]       lfsr;
  logic [AW-1:0]    idx;
  logic             push, pop;
  logic             unused_bits;
  assign idx = addr[AW+1:2];
  assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};
  assign addr_ok = resetn && (count < (PW+1)'(DEPTH)) && !(stall_en && lfsr[0]);
  assign data_ok = valid[head] && timer[head] == '0;
  assign rdata = data_ok ? qdata[head] : '0;
  assign push = req && addr_ok;
  assign pop = data_ok;
  always_ff @(posedge clk)
    if (push && wr)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      lfsr  <= 8'hA5;
      for (int i = 0; i < DEPTH; i++) begin
        qdata[i] <= '0;
        timer[i] <= '0;
      end
    end else begin
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      for (int i = 0; i < DEPTH; i++)
        if (valid[i] && timer[i] != '0) timer[i] <= timer[i] - 1'b1;
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      // a push never lands on the head being popped: a full queue refuses accepts
      if (push) begin
        valid[tail] <= 1'b1;
        timer[tail] <= TW'(RESP_DELAY - 1);
        qdata[tail] <= wr ? 32'h0 : mem[idx];
        tail        <= tail + 1'b1;
      end
    end
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: directed and randomized checks of sram_like_responder against a queue-based reference model.
module tb_sram_like_responder;
  localparam int AW = 10;
  localparam int DEPTH = 4;
  localparam int RESP_DELAY = 2;
  logic        clk = 0, resetn = 1, req = 0, req6 = 0, wr = 0, stall_en = 0;
  logic [3:0]  wstrb = 0;
  logic [1:0]  size = 2;
  logic [31:0] addr = 0, wdata = 0;
  logic        addr_ok, data_ok, addr_ok6, data_ok6;
  logic [31:0] rdata, rdata6;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {int due; logic [31:0] data;} exp_t;

  sram_like_responder #(.AW(AW), .DEPTH(DEPTH), .RESP_DELAY(RESP_DELAY)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .wstrb(wstrb), .size(size),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .stall_en(stall_en));
  sram_like_responder #(.AW(AW), .DEPTH(DEPTH), .RESP_DELAY(6)) dut6 (
    .clk(clk), .resetn(resetn), .req(req6), .wr(wr), .wstrb(wstrb), .size(size),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok6), .data_ok(data_ok6), .rdata(rdata6),
    .stall_en(stall_en));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    req = 1; wr = w; addr = a; wdata = wd; wstrb = s; size = 2'd2;
    @(posedge clk); @(negedge clk);
    req = 0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output int lat);
    lat = 0;
    while (data_ok !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = rdata;
  endtask

  task automatic test_reset;
    resetn = 1; #2 resetn = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({addr_ok, data_ok, rdata, addr_ok6, data_ok6, rdata6} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ok=%b dok=%b rdata=%h ok6=%b dok6=%b rdata6=%h exp all 0",
               addr_ok, data_ok, rdata, addr_ok6, data_ok6, rdata6);
    end
    resetn = 1;
    #1;
    checks++;
    if (addr_ok !== 1'b1 || data_ok !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got addr_ok=%b data_ok=%b exp 1 0", addr_ok, data_ok);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read;
    logic [31:0] d;
    int lat;
    issue(1, 32'h10, 32'h12345678, 4'hF);
    wait_resp(d, lat);
    checks++;
    if (lat !== RESP_DELAY - 1 || d !== 32'h0) begin
      failures++;
      $display("FAIL write_resp got lat=%0d rdata=%h exp lat=%0d rdata=0", lat, d, RESP_DELAY - 1);
    end
    @(negedge clk);
    checks++;
    if (data_ok !== 1'b0) begin
      failures++;
      $display("FAIL write_resp_width got data_ok=%b exp 0", data_ok);
    end
    issue(0, 32'h10, 32'h0, 4'h0);
    wait_resp(d, lat);
    checks++;
    if (lat !== RESP_DELAY - 1 || d !== 32'h12345678) begin
      failures++;
      $display("FAIL read_word got lat=%0d rdata=%h exp lat=%0d rdata=12345678", lat, d, RESP_DELAY - 1);
    end
    @(negedge clk);
  endtask

  task automatic test_byte_write;
    logic [31:0] d;
    int lat;
    issue(1, 32'h10, 32'h0000AB00, 4'b0010);
    wait_resp(d, lat);
    @(negedge clk);
    issue(0, 32'h10, 32'h0, 4'h0);
    wait_resp(d, lat);
    checks++;
    if (d !== 32'h1234AB78) begin
      failures++;
      $display("FAIL byte_write got %h exp 1234ab78", d);
    end
    @(negedge clk);
    issue(0, 32'h10 + (32'd4 << AW), 32'h0, 4'h0);
    wait_resp(d, lat);
    checks++;
    if (d !== 32'h1234AB78) begin
      failures++;
      $display("FAIL alias_read got %h exp 1234ab78", d);
    end
    @(negedge clk);
    issue(1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    wait_resp(d, lat);
    checks++;
    if (lat !== RESP_DELAY - 1) begin
      failures++;
      $display("FAIL zero_strobe_resp got lat=%0d exp %0d", lat, RESP_DELAY - 1);
    end
    @(negedge clk);
    issue(0, 32'h10, 32'h0, 4'h0);
    wait_resp(d, lat);
    checks++;
    if (d !== 32'h1234AB78) begin
      failures++;
      $display("FAIL zero_strobe_mem got %h exp 1234ab78", d);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic        ok [6];
    logic [31:0] rd [6];
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(1, 32'(4 * i), 32'(i + 1), 4'hF);
      wait_resp(d, lat);
      @(negedge clk);
    end
    for (int k = 0; k < 6; k++) begin
      req = k < 3; wr = 0; addr = 32'(4 * k);
      @(posedge clk); @(negedge clk);
      ok[k] = data_ok; rd[k] = rdata;
    end
    req = 0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (ok[k] !== (k >= 1 && k <= 3) || (ok[k] && rd[k] !== 32'(k))) begin
        failures++;
        $display("FAIL back_to_back[%0d] got ok=%b rdata=%h exp ok=%b rdata=%h",
                 k, ok[k], rd[k], (k >= 1 && k <= 3), 32'(k));
      end
    end
  endtask

  task automatic test_full_queue;
    logic ao [9];
    logic dk [9];
    checks++;
    if (addr_ok6 !== 1'b1) begin
      failures++;
      $display("FAIL full_initial got addr_ok=%b exp 1", addr_ok6);
    end
    req6 = 1; wr = 0; addr = 0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); @(negedge clk);
      ao[k] = addr_ok6; dk[k] = data_ok6;
    end
    req6 = 0;
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (ao[k] !== !(k >= 3 && k <= 5) || dk[k] !== (k >= 5)) begin
        failures++;
        $display("FAIL full_queue[%0d] got addr_ok=%b data_ok=%b exp %b %b",
                 k, ao[k], dk[k], !(k >= 3 && k <= 5), (k >= 5));
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] mem_m [16];
    exp_t q[$];
    logic [31:0] d, a, e;
    int lat, occ, stalls = 0, acc = 0;
    logic exp_ok;
    logic [3:0] idx;
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = $urandom;
      issue(1, 32'(4 * i), mem_m[i], 4'hF);
      wait_resp(d, lat);
      @(negedge clk);
    end
    stall_en = 1;
    for (int n = 0; n < 240; n++) begin
      @(negedge clk);
      occ = q.size();
      exp_ok = occ > 0 && q[0].due == cyc;
      checks++;
      if (data_ok !== exp_ok || (exp_ok && rdata !== q[0].data)) begin
        failures++;
        $display("FAIL bp_resp cyc=%0d got ok=%b rdata=%h exp ok=%b rdata=%h",
                 cyc, data_ok, rdata, exp_ok, exp_ok ? q[0].data : 32'h0);
      end
      if (occ > 0 && q[0].due == cyc) void'(q.pop_front());
      idx = 4'($urandom_range(0, 15));
      a = $urandom;
      a[AW+1:2] = AW'(idx);
      req = n < 200 && $urandom_range(0, 2) != 0;
      wr = 1'($urandom_range(0, 1)); addr = a; wdata = $urandom; wstrb = 4'($urandom);
      #1;
      checks++;
      if (occ == DEPTH && addr_ok !== 1'b0) begin
        failures++;
        $display("FAIL bp_full_accept cyc=%0d got addr_ok=%b exp 0", cyc, addr_ok);
      end
      if (occ < DEPTH && !addr_ok) stalls++;
      if (req && addr_ok) begin
        e = wr ? 32'h0 : mem_m[idx];
        if (wr)
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
        q.push_back('{cyc + RESP_DELAY, e});
        acc++;
      end
    end
    req = 0;
    stall_en = 0;
    checks++;
    if (q.size() != 0 || acc == 0 || stalls == 0) begin
      failures++;
      $display("FAIL bp_summary got pending=%0d accepts=%0d stalls=%0d exp pending=0 accepts>0 stalls>0",
               q.size(), acc, stalls);
    end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    req = 1; wr = 0; addr = 32'h0;
    @(posedge clk); @(negedge clk);
    addr = 32'h4;
    @(posedge clk); @(negedge clk);
    req = 0;
    checks++;
    if (data_ok !== 1'b1) begin
      failures++;
      $display("FAIL mid_pending got data_ok=%b exp 1", data_ok);
    end
    resetn = 0;
    #1;
    checks++;
    if (data_ok !== 1'b0 || addr_ok !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset got data_ok=%b addr_ok=%b rdata=%h exp 0 0 0", data_ok, addr_ok, rdata);
    end
    @(negedge clk);
    resetn = 1;
    #1;
    checks++;
    if (addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL mid_release got addr_ok=%b exp 1", addr_ok);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (data_ok !== 1'b0) begin
        failures++;
        $display("FAIL mid_stale[%0d] got data_ok=%b exp 0", k, data_ok);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_write;
    test_back_to_back;
    test_full_queue;
    test_backpressure;
    test_reset_midflight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
Target side of the sram-like req/addr_ok/data_ok bus that the core drives on its inst and data ports. It accepts requests into an in-order outstanding queue and backs them with an internal word-addressed memory. Responses come back after a fixed, parameterised delay, and optional pseudo-random addr_ok backpressure can be enabled. It serves as the bus-side model in core-level simulation, and as a simple on-chip RAM slave behind the core.

Parameters:
AW, 10, word-index width; the memory holds 2^AW 32-bit words.
DEPTH, 4, maximum number of outstanding accepted requests (power of 2, at least 2).
RESP_DELAY, 2, cycles from the accept edge to data_ok (at least 1).

Ports:
clk  input  1  clock; all state updates on the rising edge
resetn  input  1  asynchronous, active-low reset
req  input  1  request valid
wr  input  1  1 = write, 0 = read
wstrb  input  4  byte enables for a write
size  input  2  0 = byte, 1 = half, 2 = word; informational only, wstrb governs writes
addr  input  32  byte address; word index is addr[AW+1:2], higher bits alias
wdata  input  32  write data
addr_ok  output  1  request accepted when req && addr_ok at a rising edge
data_ok  output  1  response valid for the oldest outstanding request, one cycle per response
rdata  output  32  read data when data_ok is high; 0 for write responses
stall_en  input  1  enables random addr_ok backpressure

Behaviour:
- Reset (asynchronous, resetn=0):
  - count=0, all queue entries invalid, LFSR=8'hA5.
  - addr_ok=0, data_ok=0, rdata=0 while resetn is low.
  - Memory contents are not reset.
- addr_ok = resetn && (count < DEPTH) && !(stall_en && lfsr[0]).
  - It does not depend on req or wr combinationally.
  - When full, no request is accepted, even if a pop happens in the same cycle.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advances every cycle regardless of stall_en.
- Accept (req && addr_ok at edge T):
  - Write: memory[idx] byte lanes i with wstrb[i]=1 take wdata[8i+7:8i] at edge T. Entry data = 0.
  - Read: entry data = memory[idx] as read at edge T, after any write accepted at an earlier edge. Reads always return the full word; the master extracts bytes.
  - The entry is pushed at the tail with timer = RESP_DELAY-1.
- Timers: every valid entry's timer decrements each cycle and saturates at 0.
- Response:
  - data_ok = head valid && head timer == 0; rdata = head data (0 when data_ok is low).
  - The pop happens at the edge where data_ok=1. There is no ready/backpressure on data_ok.
  - Accept at edge T gives data_ok high in the cycle after edge T+RESP_DELAY-1, i.e. RESP_DELAY cycles after the accept edge.
- Ordering: responses are strictly in acceptance order, at most one per cycle. Back-to-back accepts give back-to-back data_ok.
- Simultaneous push and pop in one cycle: count is unchanged; pointers wrap modulo DEPTH.
- Reset asserted mid-operation: all outstanding requests are discarded, and no data_ok appears after resetn rises until a new accept.
- X/illegal inputs: wstrb=0 on a write leaves memory unchanged but still produces a response. size is never checked.

Test Plan:
1. RESP_DELAY=2, stall_en=0; write addr=0x10, wdata=0x12345678, wstrb=4'hF accepted at edge 0 -> data_ok=1, rdata=0 in the cycle after edge 1, high for exactly 1 cycle. A read of 0x10 then returns 0x12345678.
2. Byte write: write 0x10, wstrb=4'b0010, wdata=0x0000AB00, then read 0x10 -> rdata=0x1234AB78. Alias check: a read of 0x10+(4<<AW) returns the same value.
3. Back-to-back: reads of 0x0, 0x4, 0x8 accepted at consecutive edges (memory preloaded 1, 2, 3) -> data_ok on 3 consecutive cycles with rdata 1, 2, 3 in order.
4. Full queue: RESP_DELAY=6, req held high -> 4 accepts at edges 0-3; addr_ok=0 from edge 3 through the cycle of the first data_ok; addr_ok returns to 1 the cycle after the first pop.
5. Backpressure: stall_en=1 for 200 cycles of random reads/writes -> addr_ok low on some cycles, every accepted request receives exactly one data_ok, and the read data matches a scoreboard model.
6. Reset mid-flight: 2 reads outstanding, resetn=0 for 1 cycle -> data_ok, addr_ok and rdata are 0 immediately. After release, addr_ok=1 and no data_ok appears for 10 idle cycles.
